fifo_tx_serializer: RTL and testbench
=====================================

Name: fifo_tx_serializer

Overview:
- Downstream consumer of the synchronous FIFO. It pops one word at a time and transmits it as an asynchronous serial frame: start bit, DATA_WIDTH data bits LSB first, then stop bit(s).
- It connects directly to the FIFO's data_out, fifo_empty and read_en ports. It is the first stage of the serial TX path.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and the number of data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits new frames to start; a frame already in progress always completes.
- fifo_data  input  DATA_WIDTH  connects to the FIFO's data_out.
- fifo_empty  input  1  connects to the FIFO's fifo_empty.
- fifo_read_en  output  1  connects to the FIFO's read_en; registered; one-cycle pulse per frame.
- tx  output  1  serial line; idle level is high; registered.
- busy  output  1  high in every state except IDLE; registered.
- frame_done  output  1  one-cycle pulse when the final stop bit ends; registered.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, fifo_read_en=0, busy=0, frame_done=0.
  - state=IDLE; all counters and the shift register are cleared.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE:
  - On an edge with enable=1 and fifo_empty=0, go to POP. fifo_read_en=1 and busy=1 for the whole POP cycle.
  - Otherwise remain in IDLE with fifo_read_en=0.
- POP (1 cycle):
  - The FIFO samples read_en at the closing edge; its data_out is valid after that edge.
  - Go to LOAD; fifo_read_en returns to 0.
- LOAD (1 cycle):
  - At the closing edge, capture fifo_data into the shift register.
  - Go to START and drive tx=0.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift-register bit 0, held for CLKS_PER_BIT cycles per bit.
  - Shift right and increment the bit index after each bit.
  - After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final edge:
  - Pulse frame_done for exactly 1 cycle.
  - If enable=1 and fifo_empty=0, go directly to POP; busy stays 1 and the line gap is exactly 2 cycles of tx=1.
  - Otherwise go to IDLE with busy=0.
- Frame latency: from the first POP cycle to the frame_done pulse is 2+(1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1, then wraps.
  - Bit index is $clog2(DATA_WIDTH)+1 bits.
  - No arithmetic overflow is permitted at the parameter extremes.
- Boundary conditions:
  - fifo_read_en is never asserted while fifo_empty is high at the decision edge, so the block never underflows the FIFO.
  - fifo_empty and fifo_data are ignored outside the IDLE, STOP-end and LOAD decision points.
  - enable deasserted mid-frame: the frame completes normally and no further pop occurs.
  - enable toggling while in IDLE has no effect unless it is high at a decision edge.
  - Reset mid-frame: tx returns high immediately and the popped word is discarded. After reset release, the next FIFO word is sent normally.
  - No X on tx at any time after reset.

Test Plan:
1. Reset and idle gating: assert rst with fifo_empty=0 and enable=0 -> tx=1, busy=0, fifo_read_en=0. Release rst and keep enable=0 for 50 cycles -> no read_en pulse.
2. Single word: CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1 -> fifo_read_en high for exactly 1 cycle, then:
   - tx holds 0 for 4 cycles (start bit);
   - tx follows 1,0,1,0,0,1,0,1, each held 4 cycles;
   - tx holds 1 for 4 cycles (stop bit);
   - frame_done pulses 42 cycles after the first POP cycle;
   - busy falls on the same edge.
3. Back-to-back: fifo_rtl instance with DEPTH=8 is loaded with 1..8, enable=1 ->
   - 8 read_en pulses and 8 frames in order 0x01..0x08;
   - exactly 2 idle-high cycles between consecutive frames;
   - busy stays high throughout;
   - fifo_empty=1 after the 8th pop and the block returns to IDLE.
4. Enable drop: FIFO holds 0x3C,0x55. Deassert enable during the DATA bits of 0x3C -> 0x3C completes, no pop of 0x55, fifo_level stays 1. Reassert enable -> 0x55 is sent.
5. Asynchronous reset mid-DATA: pulse rst between clock edges during bit 3 -> tx=1 and busy=0 before the next edge. After release, the next FIFO word transmits correctly.
6. STOP_BITS=2, CLKS_PER_BIT=4, word 0xFF -> stop period high for 8 cycles; frame_done pulses 46 cycles after POP.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: pops FIFO words and sends each as an async serial frame, LSB first
module fifo_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n, baud_inc;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic baud_end, go, done_n, tx_n;
  assign baud_end = baud == BAUD_LAST;
  assign baud_inc = baud_end ? '0 : baud + 1'b1;
  assign go = enable && !fifo_empty;
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  // next-state, counters and shift register; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_n = state;
    baud_n = baud;
    idx_n = idx;
    shift_n = shift;
    done_n = 1'b0;
    case (state)
      IDLE: state_n = go ? POP : IDLE;
      POP: state_n = LOAD;
      LOAD: begin
        shift_n = fifo_data;
        baud_n = '0;
        idx_n = '0;
        state_n = START;
      end
      START: begin
        baud_n = baud_inc;
        state_n = baud_end ? DATA : START;
      end
      DATA: begin
        baud_n = baud_inc;
        if (baud_end) begin
          shift_n = shift >> 1;
          idx_n = idx == DATA_LAST ? '0 : idx + 1'b1;
          state_n = idx == DATA_LAST ? STOP : DATA;
        end
      end
      STOP: begin
        baud_n = baud_inc;
        if (baud_end) begin
          idx_n = idx == STOP_LAST ? '0 : idx + 1'b1;
          done_n = idx == STOP_LAST;
          state_n = idx == STOP_LAST ? (go ? POP : IDLE) : STOP;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs; reset forces the line idle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      fifo_read_en <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      fifo_read_en <= state_n == POP;
      tx <= tx_n;
      busy <= state_n != IDLE;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: scoreboard bench with a FIFO model, frame decoder and per-feature tasks
module tb_fifo_tx_serializer;
  localparam int DW = 8;
  localparam int CPB = 4;
  localparam int FRAME = (DW + 2) * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_empty = 1'b1;
  logic fifo_read_en, tx, busy, frame_done;
  logic enable2 = 1'b0;
  logic [DW-1:0] fifo_data2 = 8'hFF;
  logic fifo_empty2 = 1'b1;
  logic fifo_read_en2, tx2, busy2, frame_done2;
  int total = 0, bad = 0, underflow = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_w;
  logic mon_on = 1'b0, mon_cur = 1'b0, mon_err = 1'b0, gap_arm = 1'b0;
  int mon_c = 0, gap = 0, frames = 0, gaps_seen = 0, gap_err = 0;
  logic [DW-1:0] mon_w = '0, mon_exp = '0;

  fifo_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_read_en(fifo_read_en), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_tx_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .fifo_data(fifo_data2), .fifo_empty(fifo_empty2),
    .fifo_read_en(fifo_read_en2), .tx(tx2), .busy(busy2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  // synchronous FIFO model: read_en sampled at the edge, data_out valid after it
  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (fifo_q.size() == 0) underflow++;
      else begin
        pop_w = fifo_q.pop_front();
        fifo_data <= pop_w;
        fifo_empty <= (fifo_q.size() == 0);
      end
    end
  end

  // single-word source for the two-stop-bit instance
  always @(posedge clk) if (fifo_read_en2) fifo_empty2 <= 1'b1;

  // frame decoder: pops the expected word at each start bit and checks word, framing and bit hold
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mon_on = 1'b0;
      gap_arm = 1'b0;
    end else begin
      if (!mon_on && tx === 1'b0) begin
        if (gap_arm) begin
          gaps_seen++;
          if (gap != 2) gap_err++;
        end
        gap_arm = 1'b0;
        mon_on = 1'b1;
        mon_c = 0;
        mon_err = 1'b0;
        mon_w = '0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_start: got a frame start, required a queued word");
          mon_exp = '0;
        end else mon_exp = exp_q.pop_front();
      end else if (!mon_on) gap++;
      if (mon_on) begin
        if ($isunknown(tx)) mon_err = 1'b1;
        if (mon_c % CPB == 0) begin
          mon_cur = tx;
          if (mon_c / CPB >= 1 && mon_c / CPB <= DW) mon_w[mon_c / CPB - 1] = tx;
          else if (tx !== (mon_c == 0 ? 1'b0 : 1'b1)) mon_err = 1'b1;
        end else if (tx !== mon_cur) mon_err = 1'b1;
        if (mon_c == FRAME - 1) begin
          total += 2;
          if (mon_w !== mon_exp) begin
            bad++;
            $display("FAIL frame_word: got %h required %h", mon_w, mon_exp);
          end
          if (mon_err) begin
            bad++;
            $display("FAIL frame_shape: word %h got err=1 required err=0", mon_exp);
          end
          mon_on = 1'b0;
          gap = 0;
          gap_arm = 1'b1;
          frames++;
        end
        mon_c++;
      end
    end
  end

  task fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task test_reset;
    int rd;
    fifo_push(8'hA5);
    repeat (3) @(negedge clk);
    total += 4;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b required 0", fifo_read_en); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", frame_done); end
    rst = 1'b0;
    rd = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_read_en) rd++;
    end
    total++;
    if (rd != 0) begin bad++; $display("FAIL idle_gate: got %0d pops required 0", rd); end
  endtask

  task test_single;
    int rd, n, t_done, f0;
    logic started, b_done;
    f0 = frames;
    rd = 0;
    n = 0;
    t_done = -1;
    started = 1'b0;
    b_done = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 200 && t_done < 0; i++) begin
      @(negedge clk);
      if (fifo_read_en) begin rd++; started = 1'b1; end
      if (started) begin
        if (frame_done) begin t_done = n; b_done = busy; end
        n++;
      end
    end
    @(negedge clk);
    enable = 1'b0;
    total += 5;
    if (rd != 1) begin bad++; $display("FAIL single_rd: got %0d required 1", rd); end
    if (t_done != 42) begin bad++; $display("FAIL single_latency: got %0d required 42", t_done); end
    if (b_done !== 1'b0) begin bad++; $display("FAIL single_busy: got %b required 0", b_done); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b required 0", frame_done); end
    if (frames - f0 != 1) begin bad++; $display("FAIL single_frames: got %0d required 1", frames - f0); end
  endtask

  task test_back_to_back;
    int rd, dn, f0, busy_err;
    logic started, b_last;
    f0 = frames;
    gaps_seen = 0;
    gap_err = 0;
    gap_arm = 1'b0;
    for (int v = 1; v <= 8; v++) fifo_push(8'(v));
    rd = 0;
    dn = 0;
    busy_err = 0;
    started = 1'b0;
    b_last = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2000 && dn < 8; i++) begin
      @(negedge clk);
      if (fifo_read_en) begin rd++; started = 1'b1; end
      if (started) begin
        if (frame_done) begin
          dn++;
          if (dn == 8) b_last = busy;
          else if (!busy) busy_err++;
        end else if (!busy) busy_err++;
      end
    end
    enable = 1'b0;
    total += 8;
    if (rd != 8) begin bad++; $display("FAIL b2b_rd: got %0d required 8", rd); end
    if (dn != 8) begin bad++; $display("FAIL b2b_done: got %0d required 8", dn); end
    if (busy_err != 0) begin bad++; $display("FAIL b2b_busy: got %0d low cycles required 0", busy_err); end
    if (b_last !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b required 0", b_last); end
    if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b required 1", fifo_empty); end
    if (frames - f0 != 8) begin bad++; $display("FAIL b2b_frames: got %0d required 8", frames - f0); end
    if (gaps_seen != 7) begin bad++; $display("FAIL b2b_gaps: got %0d required 7", gaps_seen); end
    if (gap_err != 0) begin bad++; $display("FAIL b2b_gap_len: got %0d bad gaps required 0", gap_err); end
  endtask

  task test_enable_drop;
    int rd, dn, n, f0;
    logic started;
    f0 = frames;
    fifo_push(8'h3C);
    fifo_push(8'h55);
    rd = 0;
    dn = 0;
    n = 0;
    started = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 200 && dn < 1; i++) begin
      @(negedge clk);
      if (fifo_read_en) begin rd++; started = 1'b1; end
      if (started) begin
        if (n == 15) enable = 1'b0;
        if (frame_done) dn++;
        n++;
      end
    end
    repeat (20) begin
      @(negedge clk);
      if (fifo_read_en) rd++;
    end
    total += 4;
    if (dn != 1) begin bad++; $display("FAIL drop_done: got %0d required 1", dn); end
    if (rd != 1) begin bad++; $display("FAIL drop_rd: got %0d required 1", rd); end
    if (fifo_q.size() != 1) begin bad++; $display("FAIL drop_level: got %0d required 1", fifo_q.size()); end
    if (frames - f0 != 1) begin bad++; $display("FAIL drop_frames: got %0d required 1", frames - f0); end
    enable = 1'b1;
    dn = 0;
    for (int i = 0; i < 200 && dn < 1; i++) begin
      @(negedge clk);
      if (fifo_read_en) rd++;
      if (frame_done) dn++;
    end
    enable = 1'b0;
    total += 3;
    if (rd != 2) begin bad++; $display("FAIL resume_rd: got %0d required 2", rd); end
    if (fifo_q.size() != 0) begin bad++; $display("FAIL resume_level: got %0d required 0", fifo_q.size()); end
    if (frames - f0 != 2) begin bad++; $display("FAIL resume_frames: got %0d required 2", frames - f0); end
  endtask

  task test_reset_mid;
    int n, dn, f0;
    logic started, hit, tx_before;
    f0 = frames;
    fifo_push(8'h96);
    fifo_push(8'h4B);
    n = 0;
    started = 1'b0;
    hit = 1'b0;
    tx_before = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (fifo_read_en) started = 1'b1;
      if (started) begin
        if (n == 19) begin hit = 1'b1; tx_before = tx; end
        n++;
      end
    end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (tx_before !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b required 0", tx_before); end
    if (tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b required 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    #1 rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 300 && dn < 1; i++) begin
      @(negedge clk);
      if (frame_done) dn++;
    end
    enable = 1'b0;
    total += 3;
    if (dn != 1) begin bad++; $display("FAIL mid_after_done: got %0d required 1", dn); end
    if (frames - f0 != 1) begin bad++; $display("FAIL mid_frames: got %0d required 1", frames - f0); end
    if (fifo_q.size() != 0) begin bad++; $display("FAIL mid_level: got %0d required 0", fifo_q.size()); end
  endtask

  task test_two_stop;
    int n, t_done, low, late_low;
    logic started;
    n = 0;
    t_done = -1;
    low = 0;
    late_low = 0;
    started = 1'b0;
    fifo_empty2 = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 200 && t_done < 0; i++) begin
      @(negedge clk);
      if (fifo_read_en2) started = 1'b1;
      if (started) begin
        if (frame_done2) t_done = n;
        if (tx2 !== 1'b1) begin
          if (n >= 2 && n <= 5 && tx2 === 1'b0) low++;
          else late_low++;
        end
        n++;
      end
    end
    enable2 = 1'b0;
    total += 4;
    if (t_done != 46) begin bad++; $display("FAIL stop2_latency: got %0d required 46", t_done); end
    if (low != 4) begin bad++; $display("FAIL stop2_start: got %0d low cycles required 4", low); end
    if (late_low != 0) begin bad++; $display("FAIL stop2_high: got %0d non-high cycles required 0", late_low); end
    if (fifo_empty2 !== 1'b1) begin bad++; $display("FAIL stop2_pop: got empty=%b required 1", fifo_empty2); end
  endtask

  initial begin
    test_reset;
    test_single;
    repeat (5) @(negedge clk);
    test_back_to_back;
    repeat (5) @(negedge clk);
    test_enable_drop;
    repeat (5) @(negedge clk);
    test_reset_mid;
    repeat (5) @(negedge clk);
    test_two_stop;
    repeat (5) @(negedge clk);
    total++;
    if (underflow != 0) begin bad++; $display("FAIL underflow: got %0d required 0", underflow); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
